// File: rtl/multi_traffic_lights.sv
// N-way round-robin junction controller: one approach non-red at a time,
// all-red clearance between approaches, optional demand-actuated skip/extend.
module multi_traffic_lights #(
  parameter int N_WAYS           = 2,
  parameter int GREEN_CYCLES     = 3,
  parameter int AMBER_CYCLES     = 2,
  parameter int RED_AMBER_CYCLES = 1,
  parameter int ALLRED_CYCLES    = 1,
  parameter int DEMAND_MODE      = 0,
  localparam int AW = (N_WAYS > 2) ? $clog2(N_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_WAYS-1:0]     req,
  output logic [3*N_WAYS-1:0]   lights,
  output logic [AW-1:0]         active_way,
  output logic [1:0]            phase
);

  localparam int MAX_AG = (AMBER_CYCLES > GREEN_CYCLES) ? AMBER_CYCLES : GREEN_CYCLES;
  localparam int MAX_RA = (RED_AMBER_CYCLES > ALLRED_CYCLES) ? RED_AMBER_CYCLES : ALLRED_CYCLES;
  localparam int MAXD   = (MAX_AG > MAX_RA) ? MAX_AG : MAX_RA;
  localparam int CW     = $clog2(MAXD + 1);

  generate
    if (N_WAYS < 2 || N_WAYS > 8) begin : g_bad_n_ways
      $error("multi_traffic_lights: N_WAYS must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ALL_RED   = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } phase_t;

  phase_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [AW-1:0]         way_n, pick, rr_next;
  logic [N_WAYS-1:0]     pending, pending_n, others;
  logic [3*N_WAYS-1:0]   lights_n;
  logic                  found, allred_done, green_done;
  logic [2:0]            code_n;

  assign phase = state;

  // Round-robin search over latched requests, starting just after active_way
  // and wrapping so that active_way itself is considered last.
  always_comb begin
    pick  = active_way;
    found = 1'b0;
    for (int unsigned k = 1; k <= unsigned'(N_WAYS); k++) begin
      int unsigned idx;
      idx = (32'(active_way) + k) % unsigned'(N_WAYS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = AW'(idx);
      end
    end
  end

  always_comb begin
    others             = pending;
    others[active_way] = 1'b0;
    rr_next     = (active_way == AW'(N_WAYS - 1)) ? '0 : active_way + 1'b1;
    allred_done = (cnt == CW'(ALLRED_CYCLES - 1)) || (cnt == CW'(ALLRED_CYCLES));
    green_done  = (cnt == CW'(GREEN_CYCLES - 1)) || (cnt == CW'(GREEN_CYCLES));

    state_n = state;
    cnt_n   = cnt + 1'b1;
    way_n   = active_way;

    case (state)
      ALL_RED: begin
        if (allred_done && (DEMAND_MODE == 0 || found)) begin
          state_n = RED_AMBER;
          cnt_n   = '0;
          way_n   = (DEMAND_MODE != 0) ? pick : rr_next;
        end else if (cnt == CW'(ALLRED_CYCLES)) begin
          cnt_n = cnt;
        end
      end
      RED_AMBER: begin
        if (cnt == CW'(RED_AMBER_CYCLES - 1)) begin
          state_n = GREEN;
          cnt_n   = '0;
        end
      end
      GREEN: begin
        if (green_done && (DEMAND_MODE == 0 || (|others))) begin
          state_n = AMBER;
          cnt_n   = '0;
        end else if (cnt == CW'(GREEN_CYCLES)) begin
          cnt_n = cnt;
        end
      end
      default: begin
        if (cnt == CW'(AMBER_CYCLES - 1)) begin
          state_n = ALL_RED;
          cnt_n   = '0;
        end
      end
    endcase

    // Clearing on green entry is applied after the OR so it beats a same-edge request.
    pending_n = '0;
    if (DEMAND_MODE != 0) begin
      pending_n = pending | req;
      if (state == RED_AMBER && state_n == GREEN) pending_n[active_way] = 1'b0;
    end

    case (state_n)
      RED_AMBER: code_n = 3'b110;
      GREEN:     code_n = 3'b001;
      AMBER:     code_n = 3'b010;
      default:   code_n = 3'b100;
    endcase

    lights_n = '0;
    for (int unsigned i = 0; i < unsigned'(N_WAYS); i++) begin
      lights_n[3*i +: 3] = (AW'(i) == way_n) ? code_n : 3'b100;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ALL_RED;
      cnt        <= '0;
      active_way <= AW'(N_WAYS - 1);
      pending    <= '0;
      lights     <= {N_WAYS{3'b100}};
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_way <= way_n;
      pending    <= pending_n;
      lights     <= lights_n;
    end
  end

endmodule

// File: tb/tb_multi_traffic_lights.sv
// Bench for multi_traffic_lights: default 2-way table, 4-way fixed rotation,
// and 4-way demand-actuated skip/extend/pending sequences.
module tb_multi_traffic_lights;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic started = 1'b0;

  logic        rst0 = 1'b0;
  logic [1:0]  req0 = '0;
  logic [5:0]  u0_lights;
  logic        u0_way;
  logic [1:0]  u0_phase;

  logic        rst1 = 1'b0;
  logic [3:0]  req1 = '0;
  logic [11:0] u1_lights;
  logic [1:0]  u1_way;
  logic [1:0]  u1_phase;

  logic        rst2 = 1'b0;
  logic [3:0]  req2 = '0;
  logic [11:0] u2_lights;
  logic [1:0]  u2_way;
  logic [1:0]  u2_phase;

  multi_traffic_lights u0 (
    .clk(clk), .rst(rst0), .req(req0),
    .lights(u0_lights), .active_way(u0_way), .phase(u0_phase)
  );

  multi_traffic_lights #(.N_WAYS(4), .DEMAND_MODE(0)) u1 (
    .clk(clk), .rst(rst1), .req(req1),
    .lights(u1_lights), .active_way(u1_way), .phase(u1_phase)
  );

  multi_traffic_lights #(.N_WAYS(4), .DEMAND_MODE(1)) u2 (
    .clk(clk), .rst(rst2), .req(req2),
    .lights(u2_lights), .active_way(u2_way), .phase(u2_phase)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] code(input logic [1:0] ph);
    case (ph)
      2'd1:    return 3'b110;
      2'd2:    return 3'b001;
      2'd3:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [11:0] l4(input int way, input logic [2:0] c);
    logic [11:0] l;
    for (int i = 0; i < 4; i++) l[3*i +: 3] = (i == way) ? c : 3'b100;
    return l;
  endfunction

  function automatic int non_red(input logic [11:0] l, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (l[3*i +: 3] !== 3'b100) c++;
    return c;
  endfunction

  // At most one approach may show anything other than red.
  always @(negedge clk) begin
    if (started) begin
      chk("safety_u0", non_red({6'b100100, u0_lights}, 4) <= 1, 1);
      chk("safety_u1", non_red(u1_lights, 4) <= 1, 1);
      chk("safety_u2", non_red(u2_lights, 4) <= 1, 1);
    end
  end

  task automatic c2(input string name, input logic [1:0] ph, input int way);
    chk(name, {u2_lights, u2_phase, u2_way}, {l4(way, code(ph)), ph, 2'(way)});
  endtask

  task automatic wait2(input logic [1:0] ph, input int way, input int maxc, input string name);
    int n = 0;
    while (!(u2_phase == ph && u2_way == 2'(way)) && n < maxc) begin
      tick();
      n++;
    end
    chk(name, {u2_phase, u2_way}, {ph, 2'(way)});
  endtask

  typedef struct packed {
    logic       rst;
    logic [5:0] lights;
    logic [1:0] phase;
    logic       way;
  } vec_t;

  vec_t tab [28];

  initial begin
    tab[0]  = {1'b0, 6'b100100, 2'd0, 1'b1};
    tab[1]  = {1'b0, 6'b100100, 2'd0, 1'b1};
    tab[2]  = {1'b1, 6'b100110, 2'd1, 1'b0};
    tab[3]  = {1'b1, 6'b100001, 2'd2, 1'b0};
    tab[4]  = {1'b1, 6'b100001, 2'd2, 1'b0};
    tab[5]  = {1'b1, 6'b100001, 2'd2, 1'b0};
    tab[6]  = {1'b1, 6'b100010, 2'd3, 1'b0};
    tab[7]  = {1'b1, 6'b100010, 2'd3, 1'b0};
    tab[8]  = {1'b1, 6'b100100, 2'd0, 1'b0};
    tab[9]  = {1'b1, 6'b110100, 2'd1, 1'b1};
    tab[10] = {1'b1, 6'b001100, 2'd2, 1'b1};
    tab[11] = {1'b1, 6'b001100, 2'd2, 1'b1};
    tab[12] = {1'b1, 6'b001100, 2'd2, 1'b1};
    tab[13] = {1'b1, 6'b010100, 2'd3, 1'b1};
    tab[14] = {1'b1, 6'b010100, 2'd3, 1'b1};
    tab[15] = {1'b1, 6'b100100, 2'd0, 1'b1};
    tab[16] = {1'b1, 6'b100110, 2'd1, 1'b0};
    tab[17] = {1'b1, 6'b100001, 2'd2, 1'b0};
    tab[18] = {1'b1, 6'b100001, 2'd2, 1'b0};
    tab[19] = {1'b1, 6'b100001, 2'd2, 1'b0};
    tab[20] = {1'b1, 6'b100010, 2'd3, 1'b0};
    tab[21] = {1'b1, 6'b100010, 2'd3, 1'b0};
    tab[22] = {1'b1, 6'b100100, 2'd0, 1'b0};
    tab[23] = {1'b1, 6'b110100, 2'd1, 1'b1};
    tab[24] = {1'b1, 6'b001100, 2'd2, 1'b1};
    tab[25] = {1'b1, 6'b001100, 2'd2, 1'b1};
    tab[26] = {1'b0, 6'b100100, 2'd0, 1'b1};
    tab[27] = {1'b1, 6'b100110, 2'd1, 1'b0};

    // Default 2-way, including a reset mid-green of way1.
    for (int i = 0; i < 28; i++) begin
      rst0 = tab[i].rst;
      tick();
      started = 1'b1;
      chk($sformatf("u0_vec%0d", i), {u0_lights, u0_phase, u0_way},
          {tab[i].lights, tab[i].phase, tab[i].way});
    end

    // 4-way fixed rotation: 7 edges per way.
    rst1 = 1'b0;
    tick();
    tick();
    chk("u1_reset", {u1_lights, u1_phase, u1_way}, {l4(0, 3'b100), 2'd0, 2'd3});
    rst1 = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      int k, r, w;
      logic [1:0] ph;
      tick();
      k = (e - 1) / 7;
      r = (e - 1) % 7;
      w = k % 4;
      ph = (r == 0) ? 2'd1 : (r <= 3) ? 2'd2 : (r <= 5) ? 2'd3 : 2'd0;
      chk($sformatf("u1_edge%0d", e), {u1_lights, u1_phase, u1_way}, {l4(w, code(ph)), ph, 2'(w)});
    end

    // 4-way demand mode.
    rst2 = 1'b0;
    tick();
    tick();
    rst2 = 1'b1;
    req2 = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      c2("u2_idle", 2'd0, 3);
    end
    req2 = 4'b0100;
    tick();
    c2("u2_req2_latch", 2'd0, 3);
    req2 = '0;
    tick();
    c2("u2_way2_ra", 2'd1, 2);
    tick();
    c2("u2_way2_green", 2'd2, 2);
    req2 = 4'b0001;
    tick();
    req2 = '0;
    wait2(2'd2, 0, 20, "u2_way0_green");

    req2 = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      c2("u2_hold_way0", 2'd2, 0);
    end
    req2 = 4'b1001;
    tick();
    c2("u2_req3_latch", 2'd2, 0);
    req2 = 4'b0001;
    tick();
    c2("u2_amber_after_req3", 2'd3, 0);
    tick();
    c2("u2_amber2", 2'd3, 0);
    req2 = '0;
    tick();
    c2("u2_clearance", 2'd0, 0);
    tick();
    c2("u2_skip_to_way3", 2'd1, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      c2("u2_way3_min_green", 2'd2, 3);
    end
    tick();
    c2("u2_way3_leaves", 2'd3, 3);

    wait2(2'd1, 0, 10, "u2_way0_again");
    tick();
    c2("u2_way0_green2", 2'd2, 0);
    req2 = 4'b0010;
    tick();
    req2 = '0;
    wait2(2'd1, 1, 20, "u2_way1_ra");
    req2 = 4'b0010;
    tick();
    c2("u2_way1_green_clr", 2'd2, 1);
    req2 = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      c2("u2_way1_hold", 2'd2, 1);
    end
    req2 = 4'b1000;
    tick();
    req2 = '0;
    wait2(2'd2, 3, 20, "u2_way3_served");
    // A stale pending[1] would pull way3 out of green after its minimum.
    for (int i = 0; i < 10; i++) begin
      tick();
      c2("u2_way3_hold", 2'd2, 3);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
